// File: rtl/hmmm_pkg.sv
// Shared Hmmm fetch definitions: state encoding, halt word and default widths.
// The FETCH_SEQ_PERF_CNT_EN build also uses the counter width defined here.
package hmmm_pkg;

  localparam int unsigned FETCH_N    = 8;
  localparam int unsigned FETCH_W    = 16;
  localparam int unsigned PERF_CNT_W = 16;

  localparam logic [15:0] HMMM_HALT_WORD = 16'h0000;

  typedef enum logic [2:0] {
    ADDR  = 3'd0,
    MEM   = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    JUMP  = 3'd4,
    HALT  = 3'd5
  } fetch_state_t;

endpackage

// File: rtl/fetch_seq_if.sv
// Fetch sequencer handshake bundle: PC strobes, memory read, execute issue/complete.
// Perf counter outputs exist only when FETCH_SEQ_PERF_CNT_EN is defined.
interface fetch_seq_if
  import hmmm_pkg::*;
#(
  parameter int unsigned N = FETCH_N,
  parameter int unsigned W = FETCH_W
) ();

  logic                  pc_out;
  logic                  increment;
  logic                  jump;
  logic                  mem_req;
  logic [N-1:0]          mem_addr;
  logic                  mem_ack;
  logic [W-1:0]          mem_rdata;
  logic [W-1:0]          instr;
  logic                  instr_valid;
  logic                  instr_ready;
  logic                  exec_done;
  logic                  exec_jump;
  logic [N-1:0]          exec_target;
  logic                  halted;
`ifdef FETCH_SEQ_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] retired_cnt;
  logic [PERF_CNT_W-1:0] stall_cnt;

  modport master (
    output pc_out, increment, jump, mem_req, mem_addr, instr, instr_valid, halted,
           retired_cnt, stall_cnt,
    input  mem_ack, mem_rdata, instr_ready, exec_done, exec_jump, exec_target
  );

  modport slave (
    input  pc_out, increment, jump, mem_req, mem_addr, instr, instr_valid, halted,
           retired_cnt, stall_cnt,
    output mem_ack, mem_rdata, instr_ready, exec_done, exec_jump, exec_target
  );
`else
  modport master (
    output pc_out, increment, jump, mem_req, mem_addr, instr, instr_valid, halted,
    input  mem_ack, mem_rdata, instr_ready, exec_done, exec_jump, exec_target
  );

  modport slave (
    input  pc_out, increment, jump, mem_req, mem_addr, instr, instr_valid, halted,
    output mem_ack, mem_rdata, instr_ready, exec_done, exec_jump, exec_target
  );
`endif

endinterface

// File: rtl/fetch_perf_cnt.sv
// Retired-instruction counter (wrapping) and fetch stall counter (saturating).
// Instantiated by fetch_seq only when FETCH_SEQ_PERF_CNT_EN is defined.
module fetch_perf_cnt
  import hmmm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  retire_i,
  output logic [PERF_CNT_W-1:0] retired_cnt_o,
  output logic [PERF_CNT_W-1:0] stall_cnt_o
);

  localparam logic [PERF_CNT_W-1:0] CNT_MAX = '1;

  logic [PERF_CNT_W-1:0] retired_q;
  logic [PERF_CNT_W-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (retire_i) retired_q <= retired_q + PERF_CNT_W'(1);
      if (stall_i && (stall_q != CNT_MAX)) stall_q <= stall_q + PERF_CNT_W'(1);
    end
  end

  assign retired_cnt_o = retired_q;
  assign stall_cnt_o   = stall_q;

endmodule

// File: rtl/fetch_seq.sv
// Hmmm instruction-fetch sequencer: steers the PC over the shared bus, fetches, issues, jumps.
// Optional perf counters are built in when FETCH_SEQ_PERF_CNT_EN is defined.
module fetch_seq
  import hmmm_pkg::*;
#(
  parameter int unsigned N = FETCH_N,
  parameter int unsigned W = FETCH_W
) (
  input  logic         clk,
  input  logic         rst,
  inout  wire  [N-1:0] data,
  fetch_seq_if.master  bus
);

  fetch_state_t state_q;
  logic [N-1:0] mar_q;
  logic [N-1:0] tgt_q;
  logic [W-1:0] ir_q;
  logic         mem_req_q;
  logic         instr_valid_q;
  logic         jump_q;
  logic         halted_q;

  // Strobes are registered alongside the state so they line up with it exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ADDR;
      mar_q         <= '0;
      tgt_q         <= '0;
      ir_q          <= '0;
      mem_req_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      jump_q        <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      unique case (state_q)
        ADDR: begin
          mar_q     <= data;
          mem_req_q <= 1'b1;
          state_q   <= MEM;
        end
        MEM: begin
          if (bus.mem_ack) begin
            ir_q      <= bus.mem_rdata;
            mem_req_q <= 1'b0;
            if (bus.mem_rdata == W'(HMMM_HALT_WORD)) begin
              halted_q <= 1'b1;
              state_q  <= HALT;
            end else begin
              instr_valid_q <= 1'b1;
              state_q       <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (bus.instr_ready) begin
            instr_valid_q <= 1'b0;
            state_q       <= WAIT;
          end
        end
        WAIT: begin
          if (bus.exec_done) begin
            if (bus.exec_jump) begin
              tgt_q   <= bus.exec_target;
              jump_q  <= 1'b1;
              state_q <= JUMP;
            end else begin
              state_q <= ADDR;
            end
          end
        end
        JUMP: begin
          jump_q  <= 1'b0;
          state_q <= ADDR;
        end
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          state_q <= ADDR;
        end
      endcase
    end
  end

  // pc_out is gated by rst so the counter never drives the bus while held in reset.
  assign bus.pc_out      = (state_q == ADDR) && !rst;
  assign bus.increment   = (state_q == MEM) && bus.mem_ack;
  assign bus.jump        = jump_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mar_q;
  assign bus.instr       = ir_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.halted      = halted_q;

  assign data = jump_q ? tgt_q : {N{1'bz}};

`ifdef FETCH_SEQ_PERF_CNT_EN
  logic stall_c;
  logic retire_c;

  assign stall_c  = ((state_q == MEM) && !bus.mem_ack) || ((state_q == ISSUE) && !bus.instr_ready);
  assign retire_c = (state_q == WAIT) && bus.exec_done;

  fetch_perf_cnt u_perf_cnt (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_c),
    .retire_i      (retire_c),
    .retired_cnt_o (bus.retired_cnt),
    .stall_cnt_o   (bus.stall_cnt)
  );
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// Randomized self-checking bench for fetch_seq: a transaction-level model predicts every output.
// Perf counter checks are compiled in when FETCH_SEQ_PERF_CNT_EN is defined.
module tb_fetch_seq;
  import hmmm_pkg::*;

  localparam int unsigned N = 8;
  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_seq_if #(.N(N), .W(W)) bus ();
  wire  [N-1:0] data;
  logic [N-1:0] pc_q;

  // Program counter device sharing the bus with the sequencer.
  assign data = bus.pc_out ? pc_q : {N{1'bz}};
  always @(posedge clk) begin
    if (rst)                pc_q <= '0;
    else if (bus.jump)      pc_q <= data;
    else if (bus.increment) pc_q <= pc_q + 8'd1;
  end

  fetch_seq #(.N(N), .W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .data (data),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] mem [256];

  int ack_lo, ack_hi, rdy_lo, rdy_hi, done_lo, done_hi, jump_pct, tgt_fix;
  bit stray;

  // Expected outputs for the current cycle plus environment bookkeeping.
  bit           e_pc_out, e_req, e_valid, e_jump, e_halted, waiting;
  int           e_pc;
  logic [W-1:0] e_word;
  logic [N-1:0] e_tgt;
  int           ack_wait, rdy_wait, done_wait;
  int           e_stall, e_ret;
  int           cyc;
  int           pc_cyc[$], inc_cyc[$], val_cyc[$], addr_q[$];
  logic [N-1:0] zz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int rnd(input int lo, input int hi);
    return int'($urandom_range(32'(hi), 32'(lo)));
  endfunction

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.instr_ready = 1'b0;
    bus.exec_done = 1'b0; bus.exec_jump = 1'b0; bus.exec_target = '0;
    @(negedge clk); #1;
    chk("rst_pc_out", 32'(bus.pc_out), 32'(0));
    chk("rst_mem_req", 32'(bus.mem_req), 32'(0));
    chk("rst_valid", 32'(bus.instr_valid), 32'(0));
    chk("rst_jump", 32'(bus.jump), 32'(0));
    chk("rst_inc", 32'(bus.increment), 32'(0));
    chk("rst_halted", 32'(bus.halted), 32'(0));
    chk("rst_mar", 32'(bus.mem_addr), 32'(0));
    chk("rst_ir", 32'(bus.instr), 32'(0));
    chk("rst_bus", 32'(data), 32'(zz));
    repeat (n - 1) @(negedge clk);
    rst = 1'b0;
    e_pc_out = 1'b1; e_req = 1'b0; e_valid = 1'b0; e_jump = 1'b0; e_halted = 1'b0;
    waiting = 1'b0; e_pc = 0; e_stall = 0; e_ret = 0; cyc = 0;
    pc_cyc.delete(); inc_cyc.delete(); val_cyc.delete(); addr_q.delete();
  endtask

  // One clock cycle: check outputs, play memory/execute, advance the model.
  task automatic step();
    bit acked, accepted, dn, djump;
    bit n_pc_out, n_req, n_valid, n_jump, n_halted, n_waiting;
    logic [N-1:0] dtgt;
    int r;
    acked = 0; accepted = 0; dn = 0; djump = 0; dtgt = '0;
    #1;
    chk("pc_out", 32'(bus.pc_out), 32'(e_pc_out));
    chk("mem_req", 32'(bus.mem_req), 32'(e_req));
    chk("instr_valid", 32'(bus.instr_valid), 32'(e_valid));
    chk("jump", 32'(bus.jump), 32'(e_jump));
    chk("halted", 32'(bus.halted), 32'(e_halted));
    if (e_req) chk("mem_addr", 32'(bus.mem_addr), 32'(e_pc));
    if (e_valid) chk("instr", 32'(bus.instr), 32'(e_word));
    if (e_jump) chk("jump_bus", 32'(data), 32'(e_tgt));
`ifdef FETCH_SEQ_PERF_CNT_EN
    chk("stall_cnt", 32'(bus.stall_cnt), 32'(e_stall));
    chk("retired_cnt", 32'(bus.retired_cnt), 32'(e_ret));
`endif
    if (bus.pc_out) pc_cyc.push_back(cyc);
    if (bus.instr_valid) val_cyc.push_back(cyc);

    n_pc_out = e_jump; n_req = e_req; n_valid = e_valid; n_jump = 0;
    n_halted = e_halted; n_waiting = waiting;
    if (e_pc_out) begin
      n_req = 1;
      ack_wait = rnd(ack_lo, ack_hi);
    end

    if (e_req) begin
      if (ack_wait == 0) begin
        bus.mem_ack = 1'b1; bus.mem_rdata = mem[bus.mem_addr];
        acked = 1; n_req = 0;
        if (mem[e_pc] == 16'h0000) n_halted = 1;
        else begin
          n_valid = 1; e_word = mem[e_pc]; rdy_wait = rnd(rdy_lo, rdy_hi);
        end
      end else begin
        bus.mem_ack = 1'b0; bus.mem_rdata = W'($urandom); ack_wait--;
      end
    end else begin
      bus.mem_ack = stray && ($urandom_range(3) == 0);
      bus.mem_rdata = W'($urandom_range(1) == 0 ? 0 : $urandom);
    end

    if (e_valid) begin
      if (rdy_wait == 0) begin
        bus.instr_ready = 1'b1; accepted = 1; n_valid = 0; n_waiting = 1;
        done_wait = rnd(done_lo, done_hi);
      end else begin
        bus.instr_ready = 1'b0; rdy_wait--;
      end
    end else begin
      bus.instr_ready = stray && ($urandom_range(2) == 0);
    end

    if (waiting && done_wait == 0) begin
      dn = 1; n_waiting = 0;
      djump = ($urandom_range(99) < 32'(jump_pct));
      if (tgt_fix >= 0) dtgt = N'(tgt_fix);
      else begin
        r = rnd(0, 9);
        dtgt = (r < 2) ? 8'hFF : (r < 3) ? 8'h00 : N'($urandom);
      end
      bus.exec_done = 1'b1; bus.exec_jump = djump; bus.exec_target = dtgt;
      if (djump) begin
        n_jump = 1; e_tgt = dtgt; e_pc = int'(dtgt);
      end else begin
        n_pc_out = 1; e_pc = (e_pc + 1) % 256;
      end
    end else begin
      if (waiting) done_wait--;
      bus.exec_done = !waiting && stray && ($urandom_range(2) == 0);
      bus.exec_jump = N'($urandom_range(1)) != 0;
      bus.exec_target = N'($urandom);
    end

    #1;
    chk("increment", 32'(bus.increment), 32'(acked));
    if (bus.increment) inc_cyc.push_back(cyc);
    if (acked) addr_q.push_back(int'(bus.mem_addr));

    if (((e_req && !acked) || (e_valid && !accepted)) && e_stall < 65535) e_stall++;
    if (dn) e_ret = (e_ret + 1) % 65536;

    e_pc_out = n_pc_out; e_req = n_req; e_valid = n_valid; e_jump = n_jump;
    e_halted = n_halted; waiting = n_waiting;
    cyc++;
    @(negedge clk);
  endtask

  task automatic knobs(input int al, input int ah, input int rl, input int rh,
                       input int dl, input int dh, input int jp, input int tf, input bit st);
    ack_lo = al; ack_hi = ah; rdy_lo = rl; rdy_hi = rh; done_lo = dl; done_hi = dh;
    jump_pct = jp; tgt_fix = tf; stray = st;
  endtask

  initial begin
    int n_inc;
    zz = 'z;
    for (int i = 0; i < 256; i++) mem[i] = W'($urandom_range(16'hFFFF, 1));
    mem[0] = 16'h1234;

    // Best-case sequential fetch timing.
    knobs(0, 0, 0, 0, 0, 0, 0, -1, 0);
    do_reset(2);
    repeat (8) step();
    chk("t1_npc", 32'(pc_cyc.size() >= 2), 32'(1));
    chk("t1_pc0", 32'(pc_cyc[0]), 32'(0));
    chk("t1_inc", 32'(inc_cyc[0]), 32'(1));
    chk("t1_valid", 32'(val_cyc[0]), 32'(2));
    chk("t1_pc1", 32'(pc_cyc[1]), 32'(4));

    // Memory ack delayed three cycles.
    knobs(3, 3, 0, 0, 0, 0, 0, -1, 0);
    do_reset(1);
    repeat (8) step();
    chk("t2_inc_n", 32'(inc_cyc.size()), 32'(1));
    chk("t2_inc_at", 32'(inc_cyc[0]), 32'(4));
`ifdef FETCH_SEQ_PERF_CNT_EN
    chk("t2_stall", 32'(bus.stall_cnt), 32'(3));
`endif

    // Taken branch to 0x40.
    knobs(0, 0, 0, 0, 0, 0, 100, 8'h40, 0);
    do_reset(1);
    repeat (12) step();
    chk("t3_naddr", 32'(addr_q.size() >= 2 && pc_cyc.size() >= 2), 32'(1));
    chk("t3_cpi", 32'(pc_cyc[1] - pc_cyc[0]), 32'(5));
    chk("t3_addr", 32'(addr_q[1]), 32'(8'h40));

    // Halt word at 0x05.
    mem[5] = 16'h0000;
    knobs(0, 0, 0, 0, 0, 0, 0, -1, 1);
    do_reset(1);
    for (int i = 0; i < 80; i++) begin
      if (bus.halted) break;
      step();
    end
    chk("t4_halted", 32'(bus.halted), 32'(1));
    chk("t4_offered", 32'(val_cyc.size()), 32'(5));
    n_inc = inc_cyc.size();
    repeat (20) step();
    chk("t4_no_inc", 32'(inc_cyc.size()), 32'(n_inc));
    chk("t4_no_offer", 32'(val_cyc.size()), 32'(5));
    do_reset(1);
    repeat (4) step();
    chk("t4_restart", 32'(addr_q.size() >= 1 && addr_q[0] == 0), 32'(1));
    mem[5] = 16'h5A5A;

    // Ready held low for five cycles with stray inputs.
    knobs(0, 0, 5, 5, 0, 0, 0, -1, 1);
    do_reset(1);
    repeat (15) step();
    chk("t5_nval", 32'(val_cyc.size() >= 7), 32'(1));
    chk("t5_hold", 32'(val_cyc[5]), 32'(7));
    chk("t5_next", 32'(val_cyc[6]), 32'(11));

    // Reset while an ack is pending, then while issuing.
    knobs(5, 5, 0, 0, 0, 0, 0, -1, 0);
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      if (bus.mem_req) break;
      step();
    end
    chk("t6_in_mem", 32'(bus.mem_req), 32'(1));
    knobs(0, 0, 5, 5, 0, 0, 0, -1, 0);
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      if (bus.instr_valid) break;
      step();
    end
    chk("t6_in_issue", 32'(bus.instr_valid), 32'(1));
    do_reset(1);
    repeat (4) step();
    chk("t6_restart", 32'(addr_q.size() >= 1 && addr_q[0] == 0), 32'(1));

    // Long randomized run with branches, wraps and stray inputs.
    knobs(0, 3, 0, 3, 0, 3, 30, -1, 1);
    do_reset(1);
    repeat (3000) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Instruction-fetch sequencer that directly controls the program counter.
- Drives the counter's pc_out, increment and jump strobes over the shared address bus.
- Fetches the 16-bit Hmmm instruction word from instruction memory through a req/ack handshake and hands it downstream to execute through a valid/ready handshake.
- Receives execute's completion, with an optional jump target, and loads that target into the counter via the bus.

Parameters:
- N, 8, address/bus width; matches the program counter width.
- W, 16, instruction word width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- data  inout  N  shared address bus; the program counter drives it when pc_out=1, this block drives it only in JUMP.
- pc_out  out  1  program counter output enable.
- increment  out  1  program counter increment strobe.
- jump  out  1  program counter load-from-bus strobe.
- mem_req  out  1  instruction memory read request.
- mem_addr  out  N  read address; equals MAR.
- mem_ack  in  1  read data valid; may assert in the same cycle as mem_req.
- mem_rdata  in  W  instruction word.
- instr  out  W  instruction register (IR).
- instr_valid  out  1  IR offered to execute.
- instr_ready  in  1  execute accepts IR.
- exec_done  in  1  single-cycle pulse: execute finished.
- exec_jump  in  1  qualifies exec_done: take branch.
- exec_target  in  N  branch address, sampled with exec_done.
- halted  out  1  sticky halt indicator.

Behaviour:
- States: ADDR, MEM, ISSUE, WAIT, JUMP, HALT. Reset state is ADDR.
- Reset values (all applied at the clock edge while rst=1, regardless of state):
  - pc_out=0, increment=0, jump=0, mem_req=0, instr_valid=0, halted=0
  - MAR=0, IR=0, target register=0, data bus released (Z)
- ADDR: pc_out=1 (combinational from state); MAR<=data at the edge; next state MEM.
- MEM:
  - mem_req=1, mem_addr=MAR; hold until mem_ack=1.
  - On the ack cycle: IR<=mem_rdata and increment=1 for exactly that cycle.
  - Next state is HALT if mem_rdata==0 (Hmmm halt encoding), else ISSUE.
- ISSUE: instr_valid=1 and IR held stable until instr_ready=1; then WAIT. instr_valid never drops before acceptance.
- WAIT:
  - Ignores all inputs except exec_done.
  - exec_done with exec_jump=1: latch exec_target, go to JUMP.
  - exec_done with exec_jump=0: go to ADDR.
- JUMP: drive data=target register and jump=1 for one cycle; next state ADDR.
- HALT: halted=1; all strobes 0; bus Z; remain in HALT until rst.
- Mutual exclusion: pc_out and the bus driver are never active in the same cycle; at most one of increment/jump is asserted per cycle.
- Timing: best-case cycles per instruction (ack, ready and done all immediate):
  - 4 with no branch (ADDR, MEM, ISSUE, WAIT).
  - 5 with a branch (adds JUMP).
- Boundary conditions:
  - mem_ack outside MEM, instr_ready outside ISSUE, and exec_done outside WAIT are ignored.
  - A halt word is never offered to execute.
  - Counter wrap (0xFF+1 to 0x00) is handled by the counter; this block imposes no limit.
  - exec_target=0 is a legal jump.
  - rst in any state, including mid-handshake, aborts the transaction; mem_req and instr_valid drop in the following cycle.

Optional Feature:
- Macro FETCH_SEQ_PERF_CNT_EN.
- When defined:
  - Adds output retired_cnt [15:0], incremented on each exec_done, cleared by rst, wraps at 0xFFFF.
  - Adds output stall_cnt [15:0], incremented each cycle in MEM with mem_ack=0 or in ISSUE with instr_ready=0, saturating at 0xFFFF.
- When undefined: neither port nor any counter logic exists; core behaviour is identical.

Decomposition:
- Shared package hmmm_pkg holds:
  - the state encoding typedef (fetch_state_t)
  - HMMM_HALT_WORD = 16'h0000
  - default N/W constants
- One natural sub-module, fetch_perf_cnt, containing the two counters; instantiated only under FETCH_SEQ_PERF_CNT_EN.

Test Plan:
1. Reset, model PC=0x00, memory[0]=0x1234 with zero-latency ack, ready=1, done one cycle after issue with exec_jump=0 -> pc_out in cycle 0, mem_addr=0x00, increment pulse in cycle 1, instr=0x1234 with instr_valid in cycle 2, next pc_out in cycle 4 with PC=0x01.
2. Memory ack delayed 3 cycles -> mem_req held 4 cycles with mem_addr stable, exactly one increment pulse on the ack cycle; with FETCH_SEQ_PERF_CNT_EN, stall_cnt=3.
3. exec_done with exec_jump=1, exec_target=0x40 -> JUMP cycle drives data=0x40 with jump=1 and pc_out=0; next fetch uses mem_addr=0x40.
4. memory[0x05]=0x0000 -> halted=1, instr_valid never asserted, no further mem_req or increment for 20 cycles; rst restarts fetch at PC=0.
5. instr_ready held 0 for 5 cycles -> instr_valid and instr stable throughout; stray exec_done and mem_ack pulses during ISSUE have no effect.
6. Assert rst during MEM (ack pending) and during ISSUE -> mem_req and instr_valid go 0 the following cycle; all outputs at reset values; first fetch after release at PC=0x00.
